ball_engine: RTL and testbench

Ball motion, collision and scoring stage of the pong datapath. Sits directly downstream of the paddle-position stage: consumes the two paddle top rows `p1y`/`p2y` and advances a ball on the 64×64 playfield once per step tick. Detects paddle hits, wall bounces and misses, and keeps the scores. Drives `reset_game` back to the paddle stage to recentre paddles after each point and on a new game.

---
 rtl/ball_engine_pkg.sv | 35 +++
 rtl/ball_engine_if.sv | 26 ++
 rtl/ball_engine_step_timer.sv | 26 ++
 rtl/ball_engine.sv | 170 +++++++++++++++++
 tb/tb_ball_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ball_engine_pkg.sv
// Shared constants and types for the pong ball stage.
// Field geometry, paddle columns, FSM state encoding, position type.
// Pure declarations; no latency, no flow control.
package pong_pkg;

    // 6-bit playfield coordinate (0..63)
    typedef logic [5:0] pos_t;

    localparam pos_t FIELD_MAX = 6'd63;
    localparam pos_t CENTER    = 6'd32;
    localparam pos_t P1_X      = 6'd2;
    localparam pos_t P2_X      = 6'd61;

    // Ball columns adjacent to each paddle, where a hit is detected
    localparam pos_t HIT_L_X   = P1_X + 6'd1;
    localparam pos_t HIT_R_X   = P2_X - 6'd1;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        SCORED    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    // True when row y lies inside the paddle window py .. py+h-1.
    // Done in 7 bits so a paddle near the bottom edge never wraps to row 0.
    function automatic logic in_paddle(input pos_t y, input pos_t py, input logic [6:0] h);
        logic [6:0] y7;
        logic [6:0] top7;
        y7   = {1'b0, y};
        top7 = {1'b0, py};
        return (y7 >= top7) && (y7 <= top7 + h - 7'd1);
    endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Bundle between the paddle stage and the ball engine.
// Carries paddle rows and start in, ball position, scores and game status out.
// Purely combinational wiring; no latency, no backpressure.
interface ball_engine_if;
    logic            start;
    pong_pkg::pos_t  p1y;
    pong_pkg::pos_t  p2y;
    pong_pkg::pos_t  bx;
    pong_pkg::pos_t  by;
    logic [3:0]      sc1;
    logic [3:0]      sc2;
    logic            reset_game;
    logic            game_over;

    // master: paddle stage / controller side
    modport master (
        output start, p1y, p2y,
        input  bx, by, sc1, sc2, reset_game, game_over
    );

    // slave: the ball engine itself
    modport slave (
        input  start, p1y, p2y,
        output bx, by, sc1, sc2, reset_game, game_over
    );
endinterface

// File: rtl/ball_engine_step_timer.sv
// Free-running step timer: counts 0..STEP_CYCLES-1 and flags the last count.
// Ports: clk, reset (sync, active-high), tick (high one cycle per period).
// tick is decoded from the counter register; never stalls.
module step_timer #(
    parameter int STEP_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(STEP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ball_engine.sv
// Ball motion, paddle/wall collision, miss detection and scoring for pong.
// Ports: clk, reset (sync, active-high), bus (slave modport of ball_engine_if).
// All outputs registered; state updates on the edge ending each step tick.
module ball_engine
    import pong_pkg::*;
#(
    parameter int STEP_CYCLES = 250000,
    parameter int SERVE_STEPS = 32,
    parameter int PADDLE_H    = 5,
    parameter int WIN_SCORE   = 9
) (
    input  logic          clk,
    input  logic          reset,
    ball_engine_if.slave  bus
);
    localparam int         SW      = $clog2(SERVE_STEPS + 1);
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_STEPS - 1);
    localparam logic [3:0] WIN     = 4'(WIN_SCORE);
    localparam logic [6:0] PH      = 7'(PADDLE_H);

    logic          tick;
    state_t        state;
    pos_t          bx;
    pos_t          by;
    logic          dx_pos;   // 1: moving toward column 63
    logic          dy_pos;   // 1: moving toward row 63
    logic [3:0]    sc1;
    logic [3:0]    sc2;
    logic [SW-1:0] serve_cnt;
    logic          reset_game;
    logic          game_over;

    // next-step decode
    logic          wall_flip;
    logic          hit_l;
    logic          hit_r;
    logic          ndx;
    logic          ndy;
    pos_t          nx;
    pos_t          ny;
    logic          miss_l;
    logic          miss_r;
    logic [3:0]    sc1_inc;
    logic [3:0]    sc2_inc;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Every rule looks at the current position and direction; flips are
    // applied first, then the ball moves along the updated direction.
    always_comb begin
        wall_flip = 1'b0;
        hit_l     = 1'b0;
        hit_r     = 1'b0;
        ndx       = dx_pos;
        ndy       = dy_pos;
        nx        = bx;
        ny        = by;
        miss_l    = 1'b0;
        miss_r    = 1'b0;
        sc1_inc   = sc1;
        sc2_inc   = sc2;

        wall_flip = ((by == 6'd0) && !dy_pos) || ((by == FIELD_MAX) && dy_pos);
        hit_l     = !dx_pos && (bx == HIT_L_X) && in_paddle(by, bus.p1y, PH);
        hit_r     =  dx_pos && (bx == HIT_R_X) && in_paddle(by, bus.p2y, PH);
        ndy       = dy_pos ^ wall_flip;
        ndx       = dx_pos ^ (hit_l | hit_r);
        nx        = ndx ? bx + 6'd1 : bx - 6'd1;
        ny        = ndy ? by + 6'd1 : by - 6'd1;

        miss_l    = !dx_pos && (bx == 6'd0);
        miss_r    =  dx_pos && (bx == FIELD_MAX);

        // saturate at the winning score
        sc1_inc   = (sc1 == WIN) ? sc1 : sc1 + 4'd1;
        sc2_inc   = (sc2 == WIN) ? sc2 : sc2 + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SERVE;
            bx         <= CENTER;
            by         <= CENTER;
            dx_pos     <= 1'b1;
            dy_pos     <= 1'b1;
            sc1        <= 4'd0;
            sc2        <= 4'd0;
            serve_cnt  <= '0;
            reset_game <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            reset_game <= 1'b0;
            case (state)
                SERVE: begin
                    if (tick) begin
                        if (serve_cnt == SERVE_LAST) begin
                            serve_cnt <= '0;
                            state     <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end

                PLAY: begin
                    if (tick) begin
                        if (miss_l || miss_r) begin
                            // Ball stays put on the miss step; serve heads
                            // toward whoever conceded, dy is kept.
                            reset_game <= 1'b1;
                            if (miss_r) begin
                                sc1    <= sc1_inc;
                                dx_pos <= 1'b1;
                            end else begin
                                sc2    <= sc2_inc;
                                dx_pos <= 1'b0;
                            end
                            if ((miss_r && sc1_inc == WIN) || (miss_l && sc2_inc == WIN)) begin
                                state     <= GAME_OVER;
                                game_over <= 1'b1;
                                bx        <= CENTER;
                                by        <= CENTER;
                            end else begin
                                state <= SCORED;
                            end
                        end else begin
                            bx     <= nx;
                            by     <= ny;
                            dx_pos <= ndx;
                            dy_pos <= ndy;
                        end
                    end
                end

                SCORED: begin
                    bx        <= CENTER;
                    by        <= CENTER;
                    serve_cnt <= '0;
                    state     <= SERVE;
                end

                GAME_OVER: begin
                    if (bus.start) begin
                        sc1        <= 4'd0;
                        sc2        <= 4'd0;
                        dx_pos     <= 1'b1;
                        dy_pos     <= 1'b1;
                        serve_cnt  <= '0;
                        reset_game <= 1'b1;
                        game_over  <= 1'b0;
                        state      <= SERVE;
                    end
                end

                default: state <= SERVE;
            endcase
        end
    end

    assign bus.bx         = bx;
    assign bus.by         = by;
    assign bus.sc1        = sc1;
    assign bus.sc2        = sc2;
    assign bus.reset_game = reset_game;
    assign bus.game_over  = game_over;
endmodule

// File: tb/tb_ball_engine.sv
// Testbench for ball_engine: randomized paddles against a per-step game model.
// Compares every clock (position, scores, game_over, reset_game) plus scenario checks.
// No flow control; the bench drives paddles/start and observes registered outputs.
module tb_ball_engine;
    localparam int STEP_CYCLES = 4;
    localparam int SERVE_STEPS = 2;
    localparam int PADDLE_H    = 5;
    localparam int WIN_SCORE   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ball_engine_if bus();

    ball_engine #(
        .STEP_CYCLES (STEP_CYCLES),
        .SERVE_STEPS (SERVE_STEPS),
        .PADDLE_H    (PADDLE_H),
        .WIN_SCORE   (WIN_SCORE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Game model: mode 0 serve, 1 play, 2 game over, 3 point just scored
    int m_mode, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_serve;
    int ph;          // clocks since the last step-update edge
    bit exp_rg;
    bit rg_known;

    task automatic m_reset();
        m_mode = 0; m_x = 32; m_y = 32; m_dx = 1; m_dy = 1;
        m_s1 = 0; m_s2 = 0; m_serve = 0;
    endtask

    // One ball step following the game rules, using the paddle rows held now.
    task automatic model_tick();
        int scorer;
        int t1, t2;
        if (m_mode == 0) begin
            m_serve++;
            if (m_serve == SERVE_STEPS) begin m_mode = 1; m_serve = 0; end
        end else if (m_mode == 1) begin
            scorer = 0;
            if (m_dx < 0 && m_x == 0) scorer = 2;
            else if (m_dx > 0 && m_x == 63) scorer = 1;
            if (scorer != 0) begin
                exp_rg = 1'b1;
                if (scorer == 1) begin
                    if (m_s1 < WIN_SCORE) m_s1++;
                    m_dx = 1;
                end else begin
                    if (m_s2 < WIN_SCORE) m_s2++;
                    m_dx = -1;
                end
                if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) begin
                    m_mode = 2; m_x = 32; m_y = 32; rg_known = 1'b0;
                end else begin
                    m_mode = 3;
                end
            end else begin
                t1 = int'(bus.p1y);
                t2 = int'(bus.p2y);
                if ((m_y == 0 && m_dy < 0) || (m_y == 63 && m_dy > 0)) m_dy = -m_dy;
                if (m_dx < 0 && m_x == 3 && m_y >= t1 && m_y <= t1 + PADDLE_H - 1) m_dx = 1;
                else if (m_dx > 0 && m_x == 60 && m_y >= t2 && m_y <= t2 + PADDLE_H - 1) m_dx = -1;
                m_x += m_dx;
                m_y += m_dy;
            end
        end
    endtask

    // Advance one clock in both DUT and model, then compare.
    task automatic edge_check();
        logic [20:0] got, exp;
        @(posedge clk);
        exp_rg = 1'b0;
        rg_known = 1'b1;
        if (reset) begin
            m_reset();
            ph = 0;
        end else begin
            ph = (ph + 1) % STEP_CYCLES;
            if (m_mode == 3) begin
                m_x = 32; m_y = 32; m_mode = 0; m_serve = 0;
            end else if (m_mode == 2) begin
                if (bus.start) begin
                    m_s1 = 0; m_s2 = 0; m_dx = 1; m_dy = 1; m_serve = 0;
                    m_mode = 0; exp_rg = 1'b1;
                end
            end else if (ph == 0) begin
                model_tick();
            end
        end
        #1;
        got = {bus.bx, bus.by, bus.sc1, bus.sc2, bus.game_over};
        exp = {6'(m_x), 6'(m_y), 4'(m_s1), 4'(m_s2), (m_mode == 2)};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL state t=%0t got bx=%0d by=%0d sc=%0d/%0d go=%0b want bx=%0d by=%0d sc=%0d/%0d go=%0b",
                     $time, bus.bx, bus.by, bus.sc1, bus.sc2, bus.game_over,
                     m_x, m_y, m_s1, m_s2, (m_mode == 2));
        end
        if (rg_known) begin
            n_cmp++;
            if (bus.reset_game !== exp_rg) begin
                n_bad++;
                $display("FAIL reset_game t=%0t got %0b want %0b", $time, bus.reset_game, exp_rg);
            end
        end
    endtask

    // pol 0: paddles track the ball; 1: random; 2: p2 far away; 3: p2 at rows 58..62
    task automatic set_paddles(input int pol);
        int p;
        bus.p1y = 6'($urandom_range(0, 63));
        bus.p2y = 6'($urandom_range(0, 63));
        if (pol == 0) begin
            p = m_y - int'($urandom_range(0, PADDLE_H - 1));
            bus.p1y = 6'((p < 0) ? 0 : p);
            p = m_y - int'($urandom_range(0, PADDLE_H - 1));
            bus.p2y = 6'((p < 0) ? 0 : p);
        end else if (pol == 2) begin
            bus.p2y = 6'd5;
        end else if (pol == 3) begin
            bus.p2y = 6'd58;
        end
    endtask

    task automatic step(input int pol);
        do edge_check(); while (ph != 0);
        set_paddles(pol);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (2) edge_check();
        reset = 1'b0;
    endtask

    task automatic timeout(input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s got no_event want event_within_bound", what);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.bx !== 6'd32 || bus.by !== 6'd32 || bus.sc1 !== 4'd0 || bus.sc2 !== 4'd0 ||
            bus.reset_game !== 1'b0 || bus.game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values got bx=%0d by=%0d sc=%0d/%0d rg=%0b go=%0b want 32 32 0/0 0 0",
                     bus.bx, bus.by, bus.sc1, bus.sc2, bus.reset_game, bus.game_over);
        end
        set_paddles(1);
        step(1);
        step(1);
        n_cmp++;
        if (bus.bx !== 6'd32 || bus.by !== 6'd32) begin
            n_bad++;
            $display("FAIL serve_hold got (%0d,%0d) want (32,32)", bus.bx, bus.by);
        end
        step(1);
        n_cmp++;
        if (bus.bx !== 6'd33 || bus.by !== 6'd33) begin
            n_bad++;
            $display("FAIL first_move got (%0d,%0d) want (33,33)", bus.bx, bus.by);
        end
    endtask

    task automatic test_hit();
        bit found = 1'b0;
        do_reset();
        set_paddles(3);
        for (int i = 0; i < 60 && !found; i++) begin
            step(3);
            if (m_mode == 1 && m_x == 60 && m_y == 60 && m_dx > 0) found = 1'b1;
        end
        if (!found) timeout("hit_reach");
        else begin
            step(3);
            n_cmp++;
            if (bus.bx !== 6'd59 || bus.by !== 6'd61) begin
                n_bad++;
                $display("FAIL paddle_hit got (%0d,%0d) want (59,61)", bus.bx, bus.by);
            end
        end
    endtask

    task automatic test_miss();
        bit found = 1'b0;
        do_reset();
        set_paddles(2);
        for (int i = 0; i < 300 && !found; i++) begin
            edge_check();
            if (ph == 0) set_paddles(2);
            if (m_mode == 3) found = 1'b1;
        end
        if (!found) timeout("miss_reach");
        else begin
            n_cmp++;
            if (bus.sc1 !== 4'd1 || bus.reset_game !== 1'b1 || bus.bx !== 6'd63 || bus.by !== 6'd63) begin
                n_bad++;
                $display("FAIL miss_score got sc1=%0d rg=%0b (%0d,%0d) want 1 1 (63,63)",
                         bus.sc1, bus.reset_game, bus.bx, bus.by);
            end
            edge_check();
            n_cmp++;
            if (bus.reset_game !== 1'b0 || bus.bx !== 6'd32 || bus.by !== 6'd32) begin
                n_bad++;
                $display("FAIL after_miss got rg=%0b (%0d,%0d) want 0 (32,32)", bus.reset_game, bus.bx, bus.by);
            end
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                step(2);
                if (m_x != 32) found = 1'b1;
            end
            n_cmp++;
            if (bus.bx !== 6'd33) begin
                n_bad++;
                $display("FAIL serve_dir got bx=%0d want 33", bus.bx);
            end
        end
    endtask

    task automatic test_win();
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(2);
            if (m_mode == 2) found = 1'b1;
        end
        if (!found) timeout("win_reach");
        n_cmp++;
        if (bus.sc1 !== 4'd3 || bus.sc2 !== 4'd0 || bus.game_over !== 1'b1 ||
            bus.bx !== 6'd32 || bus.by !== 6'd32) begin
            n_bad++;
            $display("FAIL win got sc=%0d/%0d go=%0b (%0d,%0d) want 3/0 1 (32,32)",
                     bus.sc1, bus.sc2, bus.game_over, bus.bx, bus.by);
        end
        repeat (9) edge_check();
        while (ph != 1) edge_check();
        bus.start = 1'b1;
        edge_check();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.sc1 !== 4'd0 || bus.reset_game !== 1'b1 || bus.game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL new_game got sc1=%0d rg=%0b go=%0b want 0 1 0", bus.sc1, bus.reset_game, bus.game_over);
        end
        edge_check();
        // start outside GAME_OVER must do nothing
        bus.start = 1'b1;
        edge_check();
        bus.start = 1'b0;
    endtask

    task automatic test_reset_on_miss();
        bit found = 1'b0;
        set_paddles(2);
        for (int i = 0; i < 100 && !found; i++) begin
            step(2);
            if (m_mode == 1 && m_x == 63 && m_dx > 0) found = 1'b1;
        end
        if (!found) timeout("pre_miss_reach");
        else begin
            repeat (STEP_CYCLES - 1) edge_check();
            reset = 1'b1;
            edge_check();
            reset = 1'b0;
            n_cmp++;
            if (bus.sc1 !== 4'd0 || bus.sc2 !== 4'd0 || bus.bx !== 6'd32 || bus.by !== 6'd32 ||
                bus.reset_game !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_on_miss got sc=%0d/%0d (%0d,%0d) rg=%0b want 0/0 (32,32) 0",
                         bus.sc1, bus.sc2, bus.bx, bus.by, bus.reset_game);
            end
            edge_check();
            n_cmp++;
            if (bus.reset_game !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_pulse got rg=%0b want 0", bus.reset_game);
            end
            repeat (2) step(2);
        end
    endtask

    // Ball positions keep bx+by even, so the reachable paddle/wall corner on
    // the right is (60,0); with paddles always returning, play arrives there.
    task automatic test_corner();
        bit found = 1'b0;
        do_reset();
        set_paddles(0);
        for (int i = 0; i < 1500 && !found; i++) begin
            step(0);
            if (m_mode == 1 && m_x == 60 && m_y == 0 && m_dx > 0 && m_dy < 0) found = 1'b1;
        end
        if (!found) timeout("corner_reach");
        else begin
            step(0);
            n_cmp++;
            if (bus.bx !== 6'd59 || bus.by !== 6'd1) begin
                n_bad++;
                $display("FAIL corner got (%0d,%0d) want (59,1)", bus.bx, bus.by);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        set_paddles(1);
        for (int i = 0; i < 400; i++) begin
            if (m_mode == 2) begin
                bus.start = 1'b1;
                edge_check();
                bus.start = 1'b0;
            end else begin
                step(1);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.p1y = 6'd0;
        bus.p2y = 6'd0;
        m_reset();
        ph = 0;
        test_reset();
        test_hit();
        test_miss();
        test_win();
        test_reset_on_miss();
        test_corner();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got running want finished");
        $fatal(1, "watchdog expired");
    end
endmodule
